// File: rtl/counter_ctrl.sv
// Run/pause/load sequencer for the BCD counter: button sync, step prescaler, load strobe, direction.
// Optional AUTO_REVERSE_EN: ping-pong at terminal count instead of letting the counter wrap.
module counter_ctrl #(
  parameter int unsigned DIV         = 50_000_000,
  parameter int unsigned MAX         = 9999,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_load,
  input  logic        btn_dir,
  input  logic [15:0] count,
  output logic        cnt_enable,
  output logic        cnt_direction,
  output logic        cnt_load,
  output logic        tick,
  output logic [1:0]  state
);

  localparam int unsigned   PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [15:0]   TOP  = 16'(MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LOAD  = 2'b11
  } state_t;

  state_t        cur, nxt;
  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    prev_q;
  logic [3:0]    pulse;
  logic [PW-1:0] presc;
  logic          tick_d, tc, en_d, flip;

  // Bit order in the sync vector: {dir, load, stop, start}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {btn_dir, btn_load, btn_stop, btn_start};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    nxt    = cur;
    tick_d = (cur == RUN) && (presc == LAST);
    tc     = cnt_direction ? (count == TOP) : (count == '0);
    unique case (cur)
      // stop outranks start even where stop itself has no effect
      IDLE, PAUSE: begin
        if (pulse[2])                  nxt = LOAD;
        else if (pulse[0] && !pulse[1]) nxt = RUN;
      end
      RUN: begin
        if (pulse[2])      nxt = LOAD;
        else if (pulse[1]) nxt = PAUSE;
      end
      LOAD:    nxt = PAUSE;
      default: nxt = IDLE;
    endcase
`ifdef AUTO_REVERSE_EN
    en_d = tick_d & ~tc;
    flip = pulse[3] ^ (tick_d & tc);
`else
    en_d = tick_d;
    flip = pulse[3];
`endif
  end

`ifndef AUTO_REVERSE_EN
  logic unused_tc;
  always_comb unused_tc = tc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur           <= IDLE;
      presc         <= '0;
      tick          <= 1'b0;
      cnt_enable    <= 1'b0;
      cnt_load      <= 1'b0;
      cnt_direction <= 1'b1;
    end else begin
      cur <= nxt;
      if (nxt == RUN && cur != RUN)
        presc <= '0;
      else if (cur == RUN)
        presc <= (presc == LAST) ? '0 : presc + PW'(1);
      tick       <= tick_d;
      cnt_enable <= en_d;
      cnt_load   <= (nxt == LOAD);
      if (flip) cnt_direction <= ~cnt_direction;
    end
  end

  always_comb state = cur;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl (DIV=4): expected strobes are queued ahead, a monitor checks them.
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_stop, btn_load, btn_dir;
  logic [15:0] count;
  logic        cnt_enable, cnt_direction, cnt_load, tick;
  logic [1:0]  state;

  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;

`ifdef AUTO_REVERSE_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    bit          is_load;
    int unsigned at;
    bit          en;
    bit          dir;
  } exp_t;

  exp_t sb[$];

  counter_ctrl #(.DIV(4), .MAX(9999), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btn_start),
    .btn_stop     (btn_stop),
    .btn_load     (btn_load),
    .btn_dir      (btn_dir),
    .count        (count),
    .cnt_enable   (cnt_enable),
    .cnt_direction(cnt_direction),
    .cnt_load     (cnt_load),
    .tick         (tick),
    .state        (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_tick(input int unsigned at, input bit en, input bit dir);
    exp_t e;
    e.is_load = 1'b0; e.at = at; e.en = en; e.dir = dir;
    sb.push_back(e);
  endtask

  task automatic push_load(input int unsigned at);
    exp_t e;
    e.is_load = 1'b1; e.at = at; e.en = 1'b0; e.dir = 1'b0;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic to_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every strobe or load pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && (tick || cnt_enable || cnt_load)) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event @cyc %0d: tick=%b en=%b load=%b", cyc, tick, cnt_enable, cnt_load);
      end else begin
        exp_t e;
        bit   ok;
        e = sb.pop_front();
        if (e.is_load)
          ok = (cyc == e.at) && cnt_load && !tick && !cnt_enable && (state == 2'b11);
        else
          ok = (cyc == e.at) && tick && !cnt_load && (cnt_enable == e.en) && (cnt_direction == e.dir);
        if (!ok) begin
          mismatched++;
          $display("FAIL event: got cyc=%0d tick=%b en=%b dir=%b load=%b state=%0d, expected cyc=%0d load=%b en=%b dir=%b",
                   cyc, tick, cnt_enable, cnt_direction, cnt_load, state, e.at, e.is_load, e.en, e.dir);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, s, e;
    rst = 1'b0; btn_start = 0; btn_stop = 0; btn_load = 0; btn_dir = 0;
    count = 16'd5000;
    repeat (3) @(negedge clk);
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_en", 16'(cnt_enable), 16'h0);
    chk("rst_load", 16'(cnt_load), 16'h0);
    chk("rst_tick", 16'(tick), 16'h0);
    chk("rst_dir", 16'(cnt_direction), 16'h1);
    rst = 1'b1;
    @(negedge clk);

    // Start from IDLE: RUN 3 clk after the press, strobes every 4 clk
    c = cyc;
    push_tick(c + 7, 1, 1); push_tick(c + 11, 1, 1); push_tick(c + 15, 1, 1);
    btn_start = 1; @(negedge clk); btn_start = 0;
    to_cyc(c + 2);  chk("idle_before_run", 16'(state), 16'h0);
    to_cyc(c + 3);  chk("run_entry", 16'(state), 16'h1);

    // Stop, pause 20 clk, restart: prescaler restarts from zero
    to_cyc(c + 13); btn_stop = 1; @(negedge clk); btn_stop = 0;
    to_cyc(c + 15); chk("run_before_stop", 16'(state), 16'h1);
    to_cyc(c + 16); chk("pause_entry", 16'(state), 16'h2);
    s = c + 36;
    to_cyc(s);      chk("pause_hold", 16'(state), 16'h2);
    push_tick(s + 7, 1, 1); push_tick(s + 11, 1, 1); push_load(s + 12);
    btn_start = 1; @(negedge clk); btn_start = 0;
    to_cyc(s + 3);  chk("rerun_entry", 16'(state), 16'h1);

    // Load and stop together: load wins, one LOAD cycle, then PAUSE
    to_cyc(s + 9);  btn_load = 1; btn_stop = 1; @(negedge clk); btn_load = 0; btn_stop = 0;
    to_cyc(s + 13);
    chk("after_load_state", 16'(state), 16'h2);
    chk("after_load_strobe", 16'(cnt_load), 16'h0);

    // Direction toggles, held button, terminal count behaviour
    e = s + 18;
    to_cyc(e);
    push_tick(e + 7, 1, 1);
    push_tick(e + 11, 1, 1);
    push_tick(e + 15, 1, 0);
    push_tick(e + 19, 1, 1);
    push_tick(e + 23, !AR, !AR);
    push_tick(e + 27, 1, !AR);
    push_tick(e + 31, 1, !AR);
    btn_start = 1; @(negedge clk); btn_start = 0;
    to_cyc(e + 9);  btn_dir = 1; @(negedge clk); btn_dir = 0;
    to_cyc(e + 12); chk("dir_toggled", 16'(cnt_direction), 16'h0);
    to_cyc(e + 15); btn_dir = 1;
    to_cyc(e + 18); btn_dir = 0;
    chk("held_dir_single", 16'(cnt_direction), 16'h1);
    to_cyc(e + 20); count = 16'd9999;
    to_cyc(e + 24); chk("terminal_dir", 16'(cnt_direction), 16'(!AR));
    to_cyc(e + 28); count = 16'd5000;

    // Asynchronous reset while a strobe is high
    to_cyc(e + 31);
    #1 rst = 1'b0;
    #1;
    chk("async_state", 16'(state), 16'h0);
    chk("async_en", 16'(cnt_enable), 16'h0);
    chk("async_tick", 16'(tick), 16'h0);
    chk("async_load", 16'(cnt_load), 16'h0);
    chk("async_dir", 16'(cnt_direction), 16'h1);
    repeat (2) @(negedge clk);
    chk("reset_hold_state", 16'(state), 16'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
